// File: rtl/aha_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aha_sram_req_ctrl
// Description : Initiator-side controller for a single-port SRAM. It accepts
//               read/write requests on a valid/ready channel, drives the SRAM
//               pins combinationally, and returns read data through a 2-entry
//               response FIFO protected by a credit check.
//               Optional macro AHA_SRAM_REQ_CTRL_RSP_BYPASS_EN: when a read
//               word arrives and the FIFO is empty, present it on the response
//               channel in the same cycle, which gives 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_sram_req_ctrl #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      REQ_VALID,
   output logic                      REQ_READY,
   input  logic                      REQ_WRITE,
   input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
   input  logic [DATA_WIDTH/8-1:0]   REQ_WSTRB,
   input  logic [DATA_WIDTH-1:0]     REQ_WDATA,
   output logic                      RSP_VALID,
   input  logic                      RSP_READY,
   output logic [DATA_WIDTH-1:0]     RSP_RDATA,
   output logic                      SRAM_CS,
   output logic [DATA_WIDTH/8-1:0]   SRAM_WE,
   output logic [ADDR_WIDTH-1:0]     SRAM_ADDR,
   output logic [DATA_WIDTH-1:0]     SRAM_WDATA,
   input  logic [DATA_WIDTH-1:0]     SRAM_RDATA,
   output logic                      BUSY
);

   localparam int c_NBYTES = DATA_WIDTH / 8;

   // A read is in flight for exactly one cycle after it is accepted.
   logic                  r_rd_pend;
   // Two-entry response FIFO with 1-bit pointers and a separate occupancy count.
   logic [DATA_WIDTH-1:0] r_fifo [0:1];
   logic                  r_wptr;
   logic                  r_rptr;
   logic [1:0]            r_count;

   logic                  w_accept;
   logic                  w_bypass;
   logic                  w_fifo_empty;
   logic                  w_push;
   logic                  w_fifo_pop;
   logic                  w_pop;
   logic [2:0]            w_credit;

   assign w_fifo_empty = (r_count == 2'd0);

`ifdef AHA_SRAM_REQ_CTRL_RSP_BYPASS_EN
   // Arriving read word goes straight to the response port when nothing is
   // queued ahead of it; held off during reset so no stale word escapes.
   assign w_bypass = ~RESET & r_rd_pend & w_fifo_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign RSP_VALID  = ~w_fifo_empty | w_bypass;
   assign RSP_RDATA  = w_bypass ? SRAM_RDATA : r_fifo[r_rptr];
   assign w_pop      = RSP_VALID & RSP_READY;
   assign w_fifo_pop = ~w_fifo_empty & RSP_READY;
   // A bypassed word consumed this cycle never enters the FIFO.
   assign w_push     = r_rd_pend & ~(w_bypass & RSP_READY);

   // Reserve a FIFO slot for every read that could still land, so the FIFO
   // can never overflow no matter how long the consumer stalls.
   assign w_credit  = {1'b0, r_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
   assign REQ_READY = ~RESET & (w_credit < 3'd2);
   assign w_accept  = REQ_VALID & REQ_READY;

   assign SRAM_CS    = w_accept;
   assign SRAM_WE    = (w_accept & REQ_WRITE) ? REQ_WSTRB : {c_NBYTES{1'b0}};
   assign SRAM_ADDR  = REQ_ADDR;
   assign SRAM_WDATA = REQ_WDATA;

   assign BUSY = r_rd_pend | ~w_fifo_empty;

   // Track the single-cycle read-in-flight flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= w_accept & ~REQ_WRITE;
      end
   end

   // Response FIFO storage, pointers and occupancy; storage is cleared on reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= SRAM_RDATA;
            r_wptr         <= ~r_wptr;
         end
         if (w_fifo_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
      end
   end

endmodule
`default_nettype wire
